// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF types shared by the core's X-IF master side.
// Holds the ID width, the commit payload and the per-ID tracker state encoding.
package cv32e40px_core_v_xif_pkg;

    localparam int X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    // Lifecycle of one offload ID, from allocation to release.
    typedef enum logic [1:0] {
        FREE       = 2'd0,
        ISSUED_ACC = 2'd1,
        ISSUED_REJ = 2'd2,
        WAIT_RES   = 2'd3
    } x_id_state_e;

endpackage

// File: rtl/cv32e40px_x_id_tracker.sv
// X-IF offload ID tracker: allocates IDs, records issue outcome, sequences the
// in-order commit/kill stream, gates result acceptance and frees IDs.
module cv32e40px_x_id_tracker
    import cv32e40px_core_v_xif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  alloc_gnt_o,
    output logic [X_ID_WIDTH-1:0] alloc_id_o,
    input  logic                  issue_valid_i,
    input  logic                  issue_ready_i,
    input  logic                  issue_accept_i,
    input  logic                  commit_go_i,
    input  logic                  commit_kill_i,
    output logic                  x_commit_valid_o,
    output x_commit_t             x_commit_o,
    input  logic                  result_valid_i,
    input  logic [X_ID_WIDTH-1:0] result_id_i,
    output logic                  result_ready_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int NUM_IDS = 2 ** X_ID_WIDTH;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef logic [X_ID_WIDTH-1:0] id_t;

    x_id_state_e      state_q [NUM_IDS];
    x_id_state_e      state_d [NUM_IDS];
    id_t              alloc_ptr_q, alloc_ptr_d;
    id_t              commit_ptr_q, commit_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic      commit_valid_q, commit_valid_d;
    x_commit_t commit_q, commit_d;
    logic      err_q, err_d;

    logic issue_fire;
    logic commit_fire;
    logic commit_frees;
    logic result_waiting;
    logic result_fire;

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high at the rising edge; valid must not depend on ready. Issue transfers
    // additionally need alloc_gnt_o, otherwise they are ignored.
    assign alloc_id_o     = alloc_ptr_q;
    assign alloc_gnt_o    = (state_q[alloc_ptr_q] == FREE) && (count_q < DEPTH_C);
    assign issue_fire     = issue_valid_i && issue_ready_i && alloc_gnt_o;

    assign commit_fire    = (commit_go_i || commit_kill_i) &&
                            ((state_q[commit_ptr_q] == ISSUED_ACC) ||
                             (state_q[commit_ptr_q] == ISSUED_REJ));
    assign commit_frees   = commit_fire &&
                            (commit_kill_i || (state_q[commit_ptr_q] == ISSUED_REJ));

    assign result_waiting = (state_q[result_id_i] == WAIT_RES);
    assign result_ready_o = !result_valid_i || result_waiting;
    assign result_fire    = result_valid_i && result_waiting;

    always_comb begin
        state_d        = state_q;
        alloc_ptr_d    = alloc_ptr_q;
        commit_ptr_d   = commit_ptr_q;
        commit_valid_d = 1'b0;
        commit_d       = '0;
        err_d          = result_valid_i && !result_waiting;

        // Issue, commit and result always target distinct IDs because each
        // requires a different current state, so the updates never collide.
        if (commit_fire) begin
            commit_valid_d       = 1'b1;
            commit_d.id          = commit_ptr_q;
            commit_d.commit_kill = commit_kill_i;
            commit_ptr_d         = commit_ptr_q + id_t'(1);
            if (commit_frees) begin
                state_d[commit_ptr_q] = FREE;
            end else begin
                state_d[commit_ptr_q] = WAIT_RES;
            end
        end

        if (result_fire) begin
            state_d[result_id_i] = FREE;
        end

        if (issue_fire) begin
            state_d[alloc_ptr_q] = issue_accept_i ? ISSUED_ACC : ISSUED_REJ;
            alloc_ptr_d          = alloc_ptr_q + id_t'(1);
        end
    end

    // Up to two entries can be released in one cycle (commit plus result).
    assign count_d = count_q + CNT_W'(issue_fire) - CNT_W'(commit_frees) - CNT_W'(result_fire);

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (state_q[i] != FREE) begin
                busy_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                state_q[i] <= FREE;
            end
            alloc_ptr_q    <= '0;
            commit_ptr_q   <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_q       <= '0;
            err_q          <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                state_q[i] <= state_d[i];
            end
            alloc_ptr_q    <= alloc_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_q       <= commit_d;
            err_q          <= err_d;
        end
    end

    assign x_commit_valid_o = commit_valid_q;
    assign x_commit_o       = commit_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_cv32e40px_x_id_tracker.sv
// Bench for cv32e40px_x_id_tracker: directed offload sequences checked against a
// queue-based model every cycle, plus hand-computed literal checks.
module tb_cv32e40px_x_id_tracker;
    import cv32e40px_core_v_xif_pkg::*;

    localparam int DEPTH   = 4;
    localparam int NUM_IDS = 2 ** X_ID_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  alloc_gnt_o;
    logic [X_ID_WIDTH-1:0] alloc_id_o;
    logic                  iv, ir, acc, go, kill, rv;
    logic [X_ID_WIDTH-1:0] rid;
    logic                  x_commit_valid_o;
    x_commit_t             x_commit_o;
    logic                  result_ready_o;
    logic                  busy_o;
    logic                  err_o;

    int n_checks;
    int n_errors;

    cv32e40px_x_id_tracker #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_gnt_o      (alloc_gnt_o),
        .alloc_id_o       (alloc_id_o),
        .issue_valid_i    (iv),
        .issue_ready_i    (ir),
        .issue_accept_i   (acc),
        .commit_go_i      (go),
        .commit_kill_i    (kill),
        .x_commit_valid_o (x_commit_valid_o),
        .x_commit_o       (x_commit_o),
        .result_valid_i   (rv),
        .result_id_i      (rid),
        .result_ready_o   (result_ready_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Issued-but-uncommitted offloads in program order, plus the set of IDs
    // waiting for a result.
    logic [X_ID_WIDTH-1:0] exp_q[$];
    bit                    acc_q[$];
    bit                    m_wait [NUM_IDS];
    int                    next_id;
    logic                  exp_cv;
    logic [X_ID_WIDTH:0]   exp_commit;
    logic                  exp_err;

    function automatic bit m_id_free(int id);
        if (m_wait[id]) return 1'b0;
        foreach (exp_q[i]) if (int'(exp_q[i]) == id) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_outstanding();
        int n = exp_q.size();
        for (int i = 0; i < NUM_IDS; i++) n += int'(m_wait[i]);
        return n;
    endfunction

    task automatic m_reset();
        exp_q.delete();
        acc_q.delete();
        for (int i = 0; i < NUM_IDS; i++) m_wait[i] = 1'b0;
        next_id    = 0;
        exp_cv     = 1'b0;
        exp_commit = '0;
        exp_err    = 1'b0;
    endtask

    task automatic m_step();
        bit gnt, do_issue, do_commit, res_ok, id_acc;
        logic [X_ID_WIDTH-1:0] cid;
        gnt       = m_id_free(next_id) && (m_outstanding() < DEPTH);
        do_issue  = iv && ir && gnt;
        do_commit = (go || kill) && (exp_q.size() > 0);
        res_ok    = rv && m_wait[rid];
        exp_err   = rv && !m_wait[rid];
        exp_cv    = do_commit;
        exp_commit = do_commit ? {exp_q[0], kill} : '0;
        if (res_ok) m_wait[rid] = 1'b0;
        if (do_commit) begin
            cid    = exp_q.pop_front();
            id_acc = acc_q.pop_front();
            if (id_acc && !kill) m_wait[cid] = 1'b1;
        end
        if (do_issue) begin
            exp_q.push_back(X_ID_WIDTH'(next_id));
            acc_q.push_back(acc);
            next_id = (next_id + 1) % NUM_IDS;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("gnt", 32'(alloc_gnt_o), 32'(m_id_free(next_id) && (m_outstanding() < DEPTH)));
                check("alloc_id", 32'(alloc_id_o), 32'(next_id));
                check("result_ready", 32'(result_ready_o), 32'(!rv || m_wait[rid]));
                check("busy", 32'(busy_o), 32'(m_outstanding() != 0));
                check("commit_valid", 32'(x_commit_valid_o), 32'(exp_cv));
                check("commit", 32'(x_commit_o), 32'(exp_commit));
                check("err", 32'(err_o), 32'(exp_err));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        iv = 1'b0; ir = 1'b0; acc = 1'b0; go = 1'b0; kill = 1'b0; rv = 1'b0; rid = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit a);
        idle();
        iv = 1'b1; ir = 1'b1; acc = a;
    endtask

    task automatic result(input int id);
        idle();
        rv = 1'b1; rid = X_ID_WIDTH'(id);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_gnt", 32'(alloc_gnt_o), 32'd1);
        check("rst_id", 32'(alloc_id_o), 32'd0);
        check("rst_cv", 32'(x_commit_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1'b1;
        m_reset();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("init_gnt", 32'(alloc_gnt_o), 32'd1);
        check("init_id", 32'(alloc_id_o), 32'd0);
        check("init_busy", 32'(busy_o), 32'd0);
        check("init_cv", 32'(x_commit_valid_o), 32'd0);
        check("init_commit", 32'(x_commit_o), 32'd0);
        check("init_err", 32'(err_o), 32'd0);
        check("init_ready", 32'(result_ready_o), 32'd1);

        // Single accepted offload: issue, go, result.
        issue(1'b1); cyc();
        check("s1_id_after_issue", 32'(alloc_id_o), 32'd1);
        check("s1_busy", 32'(busy_o), 32'd1);
        idle(); go = 1'b1; cyc();
        check("s1_commit_valid", 32'(x_commit_valid_o), 32'd1);
        check("s1_commit", 32'(x_commit_o), 32'h00);
        result(0); #1;
        check("s1_res_ready", 32'(result_ready_o), 32'd1);
        cyc(); idle();
        check("s1_busy_fall", 32'(busy_o), 32'd0);
        check("s1_no_err", 32'(err_o), 32'd0);
        check("s1_cv_pulse", 32'(x_commit_valid_o), 32'd0);

        // Fill DEPTH entries, then an ignored fifth issue.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check("s2_alloc_id", 32'(alloc_id_o), 32'(i));
            issue(1'b1); cyc();
        end
        idle(); #1;
        check("s2_gnt_full", 32'(alloc_gnt_o), 32'd0);
        check("s2_id_full", 32'(alloc_id_o), 32'd4);
        issue(1'b1); cyc(); idle();
        check("s2_ignored_id", 32'(alloc_id_o), 32'd4);
        check("s2_ignored_gnt", 32'(alloc_gnt_o), 32'd0);

        // Two accepted, results returned out of order; early result refused.
        do_reset();
        issue(1'b1); cyc();
        issue(1'b1); cyc();
        result(0); go = 1'b1; #1;
        check("s3_early_ready", 32'(result_ready_o), 32'd0);
        cyc();
        check("s3_early_err", 32'(err_o), 32'd1);
        check("s3_commit0", 32'(x_commit_o), 32'h00);
        idle(); go = 1'b1; cyc();
        check("s3_commit1", 32'(x_commit_o), 32'h02);
        result(1); cyc();
        result(0); cyc(); idle();
        check("s3_busy", 32'(busy_o), 32'd0);
        check("s3_gnt", 32'(alloc_gnt_o), 32'd1);
        check("s3_err", 32'(err_o), 32'd0);

        // Rejected offload still commits, then its result is an error.
        do_reset();
        issue(1'b0); cyc();
        idle(); go = 1'b1; cyc();
        check("s4_cv", 32'(x_commit_valid_o), 32'd1);
        check("s4_commit", 32'(x_commit_o), 32'h00);
        check("s4_busy", 32'(busy_o), 32'd0);
        idle(); go = 1'b1; cyc();
        check("s4_no_eligible", 32'(x_commit_valid_o), 32'd0);
        result(0); cyc(); idle();
        check("s4_err", 32'(err_o), 32'd1);
        cyc();
        check("s4_err_pulse", 32'(err_o), 32'd0);

        // Kill twice (second with go as well: kill dominates).
        do_reset();
        issue(1'b1); cyc();
        issue(1'b1); cyc();
        idle(); kill = 1'b1; cyc();
        check("s5_kill0", 32'(x_commit_o), 32'h01);
        idle(); kill = 1'b1; go = 1'b1; cyc();
        check("s5_kill1", 32'(x_commit_o), 32'h03);
        check("s5_busy", 32'(busy_o), 32'd0);
        result(0); cyc();
        check("s5_err0", 32'(err_o), 32'd1);
        result(1); cyc(); idle();
        check("s5_err1", 32'(err_o), 32'd1);

        // Sixteen sequential rounds to wrap the ID space.
        do_reset();
        for (int r = 0; r < NUM_IDS; r++) begin
            check("s6_round_id", 32'(alloc_id_o), 32'(r));
            issue(1'b1); cyc();
            idle(); go = 1'b1; cyc();
            result(r); cyc();
        end
        idle(); #1;
        check("s6_wrap_id", 32'(alloc_id_o), 32'd0);

        // Overlapping issue, commit and result in the same cycles.
        issue(1'b1); cyc();
        issue(1'b1); go = 1'b1; cyc();
        issue(1'b0); go = 1'b1; rv = 1'b1; rid = 4'd0; cyc();
        idle(); go = 1'b1; rv = 1'b1; rid = 4'd1; cyc();
        check("s7_commit2", 32'(x_commit_o), 32'h04);
        idle(); cyc();
        check("s7_busy", 32'(busy_o), 32'd0);

        // Reset with two outstanding entries.
        issue(1'b1); cyc();
        issue(1'b1); cyc();
        do_reset();
        idle(); cyc();
        check("s8_no_kill", 32'(x_commit_valid_o), 32'd0);
        check("s8_id", 32'(alloc_id_o), 32'd0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
